// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the WM8731 configuration sequencer.
// Holds the FSM state encoding, codec register addresses and write-word field widths.
package codec_cfg_pkg;

    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    localparam int NUM_REGS   = 11;
    localparam int DEV_ADDR_W = 8;
    localparam int REG_ADDR_W = 7;
    localparam int REG_DATA_W = 9;
    localparam int ENTRY_W    = REG_ADDR_W + REG_DATA_W;
    localparam int WORD_W     = DEV_ADDR_W + ENTRY_W;

    localparam logic [REG_ADDR_W-1:0] REG_LLINE_IN   = 7'd0;
    localparam logic [REG_ADDR_W-1:0] REG_RLINE_IN   = 7'd1;
    localparam logic [REG_ADDR_W-1:0] REG_LHP_OUT    = 7'd2;
    localparam logic [REG_ADDR_W-1:0] REG_RHP_OUT    = 7'd3;
    localparam logic [REG_ADDR_W-1:0] REG_ANA_PATH   = 7'd4;
    localparam logic [REG_ADDR_W-1:0] REG_DIG_PATH   = 7'd5;
    localparam logic [REG_ADDR_W-1:0] REG_PWR_DOWN   = 7'd6;
    localparam logic [REG_ADDR_W-1:0] REG_DIG_IF     = 7'd7;
    localparam logic [REG_ADDR_W-1:0] REG_SAMPLING   = 7'd8;
    localparam logic [REG_ADDR_W-1:0] REG_ACTIVE     = 7'd9;
    localparam logic [REG_ADDR_W-1:0] REG_RESET      = 7'd15;

endpackage

// File: rtl/codec_cfg_rom.sv
// Fixed WM8731 bring-up table: index -> {reg_addr, reg_data}.
// Indices past the end of the table read as zero.
module codec_cfg_rom
    import codec_cfg_pkg::*;
(
    input  logic [3:0]  i_index,
    output logic [15:0] o_entry
);

    always_comb begin
        o_entry = '0;
        case (i_index)
            4'd0:    o_entry = {REG_RESET,    9'h000};
            4'd1:    o_entry = {REG_PWR_DOWN, 9'h000};
            4'd2:    o_entry = {REG_LLINE_IN, 9'h017};
            4'd3:    o_entry = {REG_RLINE_IN, 9'h017};
            4'd4:    o_entry = {REG_LHP_OUT,  9'h079};
            4'd5:    o_entry = {REG_RHP_OUT,  9'h079};
            4'd6:    o_entry = {REG_ANA_PATH, 9'h012};
            4'd7:    o_entry = {REG_DIG_PATH, 9'h000};
            4'd8:    o_entry = {REG_DIG_IF,   9'h042};
            4'd9:    o_entry = {REG_SAMPLING, 9'h000};
            4'd10:   o_entry = {REG_ACTIVE,   9'h001};
            default: o_entry = '0;
        endcase
    end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Walks the WM8731 register table after power-up, handing each entry to the I2C
// engine over a go/done handshake, with per-entry retry on NACK or timeout.
module codec_cfg_sequencer
    import codec_cfg_pkg::*;
#(
    parameter int          POWERUP_CYCLES = 50000,
    parameter int          GAP_CYCLES     = 500,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter int          MAX_RETRY      = 3,
    parameter logic [7:0]  DEV_ADDR       = 8'h34
) (
    input  logic        clk,
    input  logic        KEY,
    input  logic        i2c_busy,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        i2c_go,
    output logic [23:0] i2c_word,
    output logic [3:0]  cfg_index,
    output logic        cfg_done,
    output logic        cfg_error
);

    localparam logic [31:0] PWR_LAST   = 32'(POWERUP_CYCLES - 1);
    localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  RETRY_MAX  = 8'(MAX_RETRY);
    localparam logic [3:0]  LAST_INDEX = 4'(NUM_REGS - 1);

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_cnt, w_cnt_nxt;
    logic [3:0]    r_index, w_index_nxt;
    logic [7:0]    r_retry, w_retry_nxt;
    logic          r_go, w_go_nxt;
    logic [23:0]   r_word, w_word_nxt;
    logic [15:0]   w_rom_entry;
    logic          w_fail;

    codec_cfg_rom u_rom (
        .i_index (r_index),
        .o_entry (w_rom_entry)
    );

    always_ff @(posedge clk) begin
        if (!KEY) begin
            r_state <= S_PWRUP;
            r_cnt   <= '0;
            r_index <= '0;
            r_retry <= '0;
            r_go    <= 1'b0;
            r_word  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_index <= w_index_nxt;
            r_retry <= w_retry_nxt;
            r_go    <= w_go_nxt;
            r_word  <= w_word_nxt;
        end
    end

    // One shared counter serves power-up delay, transfer timeout and inter-write gap.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_index_nxt = r_index;
        w_retry_nxt = r_retry;
        w_go_nxt    = 1'b0;
        w_word_nxt  = r_word;
        w_fail      = 1'b0;

        case (r_state)
            S_PWRUP: begin
                if (r_cnt == PWR_LAST) begin
                    w_state_nxt = S_ISSUE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            S_ISSUE: begin
                if (!i2c_busy) begin
                    w_word_nxt  = {DEV_ADDR, w_rom_entry};
                    w_go_nxt    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i2c_done) begin
                    if (!i2c_nack) begin
                        w_retry_nxt = '0;
                        if (r_index == LAST_INDEX) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_index_nxt = r_index + 4'd1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_GAP;
                        end
                    end else begin
                        w_fail = 1'b1;
                    end
                end else if (r_cnt == TO_LAST) begin
                    w_fail = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = S_ISSUE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            S_DONE:  w_state_nxt = S_DONE;
            S_ERROR: w_state_nxt = S_ERROR;
            default: w_state_nxt = S_PWRUP;
        endcase

        // A NACK or timeout consumes one attempt; the index stays on the failing entry.
        if (w_fail) begin
            w_retry_nxt = r_retry + 8'd1;
            w_cnt_nxt   = '0;
            if (r_retry + 8'd1 == RETRY_MAX) begin
                w_state_nxt = S_ERROR;
            end else begin
                w_state_nxt = S_GAP;
            end
        end
    end

    assign i2c_go    = r_go;
    assign i2c_word  = r_word;
    assign cfg_index = r_index;
    assign cfg_done  = (r_state == S_DONE);
    assign cfg_error = (r_state == S_ERROR);

endmodule
